// File: rtl/umul_arb_pkg.sv
// Shared types and constants for the arbitrated iterative unsigned multiplier.
// Consumers: umul_8b_iter and umul_8b_arb_seq.
package umul_arb_pkg;

    localparam int NBITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [2*NBITS_DEFAULT-1:0] prod_t;

endpackage

// File: rtl/umul_8b_iter.sv
// Shift-add datapath: one partial-product step per cycle under FSM control.
// Optional macro UMUL_ARB_EARLY_TERM_EN ends the run once the multiplier is exhausted.
module umul_8b_iter
    import umul_arb_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_s,
    input  logic               step_s,
    input  logic [NBITS-1:0]   in0_s,
    input  logic [NBITS-1:0]   in1_s,
    output logic               last_step_s,
    output logic [2*NBITS-1:0] acc_nxt_s
);

    localparam int CW = $clog2(NBITS + 1);

    logic [2*NBITS-1:0] a_r;
    logic [2*NBITS-1:0] acc_r;
    logic [NBITS-1:0]   b_r;
    logic [CW-1:0]      count_r;
    logic [NBITS-1:0]   b_nxt_s;

    // Next accumulator/multiplier values and detection of the final step
    always_comb begin
        b_nxt_s = b_r >> 1;
        if (b_r[0]) begin
            acc_nxt_s = acc_r + a_r;
        end else begin
            acc_nxt_s = acc_r;
        end
`ifdef UMUL_ARB_EARLY_TERM_EN
        last_step_s = (count_r == CW'(NBITS - 1)) || (b_nxt_s == {NBITS{1'b0}});
`else
        last_step_s = (count_r == CW'(NBITS - 1));
`endif
    end

    // Operand, accumulator and step-count registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_r     <= {(2*NBITS){1'b0}};
            b_r     <= {NBITS{1'b0}};
            acc_r   <= {(2*NBITS){1'b0}};
            count_r <= {CW{1'b0}};
        end else if (start_s) begin
            a_r     <= {{NBITS{1'b0}}, in0_s};
            b_r     <= in1_s;
            acc_r   <= {(2*NBITS){1'b0}};
            count_r <= {CW{1'b0}};
        end else if (step_s) begin
            a_r     <= a_r << 1;
            b_r     <= b_nxt_s;
            acc_r   <= acc_nxt_s;
            count_r <= count_r + CW'(1);
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/umul_8b_arb_seq.sv
// Two-port round-robin front end sharing one iterative shift-add multiplier.
// Optional macro UMUL_ARB_EARLY_TERM_EN (in umul_8b_iter) shortens CALC for small multipliers.
module umul_8b_arb_seq
    import umul_arb_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_val,
    output logic               req0_rdy,
    input  logic [NBITS-1:0]   req0_in0,
    input  logic [NBITS-1:0]   req0_in1,
    input  logic               req1_val,
    output logic               req1_rdy,
    input  logic [NBITS-1:0]   req1_in0,
    input  logic [NBITS-1:0]   req1_in1,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic               resp_id,
    output logic [2*NBITS-1:0] resp_out
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic               ptr_r;
    logic               id_r;
    logic               resp_val_r;
    logic               resp_id_r;
    logic [2*NBITS-1:0] resp_out_r;

    logic               grant_s;
    logic               fire_s;
    logic               step_s;
    logic               last_step_s;
    logic [NBITS-1:0]   in0_sel_s;
    logic [NBITS-1:0]   in1_sel_s;
    logic [2*NBITS-1:0] acc_nxt_s;

    // Round-robin grant, ready generation and next-state selection
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        fire_s      = 1'b0;
        step_s      = 1'b0;
        req0_rdy    = 1'b0;
        req1_rdy    = 1'b0;
        case (state_r)
            IDLE: begin
                // On a tie the pointer names the last winner, so the other side goes
                if (req0_val && req1_val) begin
                    grant_s = ~ptr_r;
                end else if (req1_val) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                fire_s   = req0_val || req1_val;
                req0_rdy = fire_s && !grant_s;
                req1_rdy = fire_s && grant_s;
                if (fire_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (last_step_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand select for the granted requester
    always_comb begin
        if (grant_s) begin
            in0_sel_s = req1_in0;
            in1_sel_s = req1_in1;
        end else begin
            in0_sel_s = req0_in0;
            in1_sel_s = req0_in1;
        end
    end

    umul_8b_iter #(
        .NBITS (NBITS)
    ) u_iter (
        .clk         (clk),
        .reset       (reset),
        .start_s     (fire_s),
        .step_s      (step_s),
        .in0_s       (in0_sel_s),
        .in1_s       (in1_sel_s),
        .last_step_s (last_step_s),
        .acc_nxt_s   (acc_nxt_s)
    );

    // State, owner tag, arbitration pointer and registered response
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            ptr_r      <= 1'b1;
            id_r       <= 1'b0;
            resp_val_r <= 1'b0;
            resp_id_r  <= 1'b0;
            resp_out_r <= {(2*NBITS){1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (fire_s) begin
                id_r <= grant_s;
            end else begin
                id_r <= id_r;
            end
            // Pointer moves only on the response handshake, never on grant
            if ((state_r == CALC) && last_step_s) begin
                resp_val_r <= 1'b1;
                resp_id_r  <= id_r;
                resp_out_r <= acc_nxt_s;
                ptr_r      <= ptr_r;
            end else if ((state_r == DONE) && resp_rdy) begin
                resp_val_r <= 1'b0;
                resp_id_r  <= resp_id_r;
                resp_out_r <= resp_out_r;
                ptr_r      <= id_r;
            end else begin
                resp_val_r <= resp_val_r;
                resp_id_r  <= resp_id_r;
                resp_out_r <= resp_out_r;
                ptr_r      <= ptr_r;
            end
        end
    end

    assign resp_val = resp_val_r;
    assign resp_id  = resp_id_r;
    assign resp_out = resp_out_r;

endmodule

// File: tb/tb_umul_8b_arb_seq.sv
// Self-checking bench for umul_8b_arb_seq: directed scenarios plus a randomized
// two-requester run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_umul_8b_arb_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_val = 1'b0;
    logic        req0_rdy;
    logic [7:0]  req0_in0 = 8'd0;
    logic [7:0]  req0_in1 = 8'd0;
    logic        req1_val = 1'b0;
    logic        req1_rdy;
    logic [7:0]  req1_in0 = 8'd0;
    logic [7:0]  req1_in1 = 8'd0;
    logic        resp_val;
    logic        resp_rdy = 1'b1;
    logic        resp_id;
    logic [15:0] resp_out;

    int vectors = 0;
    int miscompares = 0;

    umul_8b_arb_seq dut (
        .clk      (clk),
        .reset    (reset),
        .req0_val (req0_val),
        .req0_rdy (req0_rdy),
        .req0_in0 (req0_in0),
        .req0_in1 (req0_in1),
        .req1_val (req1_val),
        .req1_rdy (req1_rdy),
        .req1_in0 (req1_in0),
        .req1_in1 (req1_in1),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_id  (resp_id),
        .resp_out (resp_out)
    );

    always #5 clk = ~clk;

    // CALC cycles implied by the multiplier value
    function automatic int exp_lat(input logic [7:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) n = i + 1;
        end
`ifdef UMUL_ARB_EARLY_TERM_EN
        return (n == 0) ? 1 : n;
`else
        return 8;
`endif
    endfunction

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return 16'(p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 40 && !ok; i++) begin
            tick();
            if (resp_val === 1'b1) begin
                ok  = 1'b1;
                cyc = i;
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req0_val = 1'b0;
        req1_val = 1'b0;
        resp_rdy = 1'b1;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        resp_rdy = 1'b1;
        tick();
        tick();
        vectors++;
        if (resp_val !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_val: got %b expected 0", resp_val);
        end
        vectors++;
        if (resp_out !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_out: got %0d expected 0", resp_out);
        end
        vectors++;
        if (resp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_id: got %b expected 0", resp_id);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        int cyc;
        bit ok;
        req0_in0 = 8'd12;
        req0_in1 = 8'd13;
        req0_val = 1'b1;
        #1;
        vectors++;
        if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_rdy: got %b%b expected 10", req0_rdy, req1_rdy);
        end
        tick();
        req0_val = 1'b0;
        req0_in0 = 8'hFF;
        wait_resp(cyc, ok);
        vectors++;
        if (!ok || cyc != exp_lat(8'd13)) begin
            miscompares++;
            $display("FAIL single_lat: got %0d expected %0d", cyc, exp_lat(8'd13));
        end
        vectors++;
        if (resp_out !== 16'd156 || resp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL single_out: got %0d id %b expected 156 id 0", resp_out, resp_id);
        end
        tick();
        vectors++;
        if (resp_val !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drop: got %b expected 0", resp_val);
        end
    endtask

    task automatic test_tie();
        int cyc;
        bit ok;
        do_reset();
        req0_in0 = 8'd255; req0_in1 = 8'd255;
        req1_in0 = 8'd130; req1_in1 = 8'd100;
        req0_val = 1'b1;   req1_val = 1'b1;
        #1;
        vectors++;
        if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL tie1_rdy: got %b%b expected 10", req0_rdy, req1_rdy);
        end
        tick();
        req0_val = 1'b0;
        wait_resp(cyc, ok);
        vectors++;
        if (!ok || resp_out !== 16'hFE01 || resp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL tie1_out: got %h id %b expected fe01 id 0", resp_out, resp_id);
        end
        vectors++;
        if (req1_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_rdy: got %b expected 0", req1_rdy);
        end
        tick();
        vectors++;
        if (resp_val !== 1'b0 || req1_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL tie2_rdy: got val %b rdy %b expected 0 1", resp_val, req1_rdy);
        end
        tick();
        req1_val = 1'b0;
        wait_resp(cyc, ok);
        vectors++;
        if (!ok || cyc != exp_lat(8'd100)) begin
            miscompares++;
            $display("FAIL tie2_lat: got %0d expected %0d", cyc, exp_lat(8'd100));
        end
        vectors++;
        if (resp_out !== 16'd13000 || resp_id !== 1'b1) begin
            miscompares++;
            $display("FAIL tie2_out: got %0d id %b expected 13000 id 1", resp_out, resp_id);
        end
        req0_in0 = 8'd3; req0_in1 = 8'd5;
        req1_in0 = 8'd7; req1_in1 = 8'd9;
        req0_val = 1'b1; req1_val = 1'b1;
        tick();
        vectors++;
        if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL tie3_rdy: got %b%b expected 10", req0_rdy, req1_rdy);
        end
        tick();
        req0_val = 1'b0; req1_val = 1'b0;
        wait_resp(cyc, ok);
        vectors++;
        if (!ok || resp_out !== 16'd15 || resp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL tie3_out: got %0d id %b expected 15 id 0", resp_out, resp_id);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        bit ok;
        resp_rdy = 1'b0;
        req0_in0 = 8'd42; req0_in1 = 8'd90;
        req0_val = 1'b1;
        #1;
        tick();
        req0_val = 1'b0;
        wait_resp(cyc, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_timeout: got no response expected resp_val");
        end
        for (int k = 0; k < 5; k++) begin
            req0_val = 1'b1; req1_val = 1'b1;
            req0_in0 = 8'($urandom_range(0, 255));
            #1;
            vectors++;
            if (resp_val !== 1'b1 || resp_out !== 16'd3780 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got val %b out %0d rdy %b%b expected 1 3780 00",
                         k, resp_val, resp_out, req0_rdy, req1_rdy);
            end
            tick();
        end
        req0_val = 1'b0; req1_val = 1'b0;
        resp_rdy = 1'b1;
        tick();
        vectors++;
        if (resp_val !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got %b expected 0", resp_val);
        end
        req1_val = 1'b1;
        #1;
        vectors++;
        if (req1_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_idle: got %b expected 1", req1_rdy);
        end
        req1_val = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        bit ok;
        req0_in0 = 8'd20; req0_in1 = 8'd16;
        req0_val = 1'b1;
        #1;
        tick();
        req0_val = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (resp_val !== 1'b0 || resp_out !== 16'd0) begin
            miscompares++;
            $display("FAIL rstmid_clear: got val %b out %0d expected 0 0", resp_val, resp_out);
        end
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (resp_val === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL rstmid_ghost: got %0d responses expected 0", seen);
        end
        req1_in0 = 8'd2; req1_in1 = 8'd3;
        req1_val = 1'b1;
        #1;
        tick();
        req1_val = 1'b0;
        wait_resp(cyc, ok);
        vectors++;
        if (!ok || cyc != exp_lat(8'd3) || resp_out !== 16'd6 || resp_id !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_next: got lat %0d out %0d id %b expected %0d 6 1",
                     cyc, resp_out, resp_id, exp_lat(8'd3));
        end
        tick();
    endtask

    task automatic test_early_term();
        logic [7:0] mults [3];
        int cyc;
        bit ok;
        mults[0] = 8'd0; mults[1] = 8'd1; mults[2] = 8'd128;
        for (int k = 0; k < 3; k++) begin
            req0_in0 = 8'd8; req0_in1 = mults[k];
            req0_val = 1'b1;
            #1;
            tick();
            req0_val = 1'b0;
            wait_resp(cyc, ok);
            vectors++;
            if (!ok || cyc != exp_lat(mults[k])) begin
                miscompares++;
                $display("FAIL et_lat%0d: got %0d expected %0d", k, cyc, exp_lat(mults[k]));
            end
            vectors++;
            if (resp_out !== prod(8'd8, mults[k])) begin
                miscompares++;
                $display("FAIL et_out%0d: got %0d expected %0d", k, resp_out, prod(8'd8, mults[k]));
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit         v [2];
        logic [7:0] op0 [2];
        logic [7:0] op1 [2];
        bit         in_flight, mptr, exp_id, g, er0, er1, exp_rv;
        logic [15:0] exp_prod;
        int issued, received, lat, age, cycles;
        do_reset();
        v[0] = 1'b0; v[1] = 1'b0;
        in_flight = 1'b0; mptr = 1'b1; exp_id = 1'b0; exp_prod = 16'd0;
        issued = 0; received = 0; lat = 0; age = 0; cycles = 0;
        while (received < 20 && cycles < 4000) begin
            cycles++;
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && (issued + int'(v[0]) + int'(v[1])) < 20 && $urandom_range(0, 1) == 1) begin
                    v[i]   = 1'b1;
                    op0[i] = 8'($urandom_range(0, 255));
                    op1[i] = 8'($urandom_range(0, 255));
                end else if (!v[i]) begin
                    op0[i] = 8'($urandom_range(0, 255));
                    op1[i] = 8'($urandom_range(0, 255));
                end
            end
            req0_val = v[0]; req0_in0 = op0[0]; req0_in1 = op1[0];
            req1_val = v[1]; req1_in0 = op0[1]; req1_in1 = op1[1];
            resp_rdy = ($urandom_range(0, 3) != 0);
            #1;
            g   = (v[0] && v[1]) ? ~mptr : v[1];
            er0 = !in_flight && v[0] && !g;
            er1 = !in_flight && v[1] && g;
            exp_rv = in_flight && (age >= lat);
            vectors++;
            if (req0_rdy !== er0 || req1_rdy !== er1) begin
                miscompares++;
                $display("FAIL rnd_rdy c%0d: got %b%b expected %b%b", cycles, req0_rdy, req1_rdy, er0, er1);
            end
            vectors++;
            if (resp_val !== exp_rv) begin
                miscompares++;
                $display("FAIL rnd_val c%0d: got %b expected %b", cycles, resp_val, exp_rv);
            end
            if (exp_rv) begin
                vectors++;
                if (resp_out !== exp_prod || resp_id !== exp_id) begin
                    miscompares++;
                    $display("FAIL rnd_out c%0d: got %0d id %b expected %0d id %b",
                             cycles, resp_out, resp_id, exp_prod, exp_id);
                end
            end
            @(posedge clk);
            if (er0 || er1) begin
                exp_id    = er1;
                exp_prod  = prod(op0[er1 ? 1 : 0], op1[er1 ? 1 : 0]);
                lat       = exp_lat(op1[er1 ? 1 : 0]);
                age       = 0;
                in_flight = 1'b1;
                v[er1 ? 1 : 0] = 1'b0;
                issued++;
            end else if (exp_rv && resp_rdy) begin
                in_flight = 1'b0;
                mptr      = exp_id;
                received++;
            end else if (in_flight) begin
                age++;
            end
            #1;
        end
        vectors++;
        if (received != 20 || issued != 20) begin
            miscompares++;
            $display("FAIL rnd_count: got issued %0d received %0d expected 20 20", issued, received);
        end
        req0_val = 1'b0; req1_val = 1'b0;
        resp_rdy = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_early_term();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
